// File: rtl/rfBlackWidowPkg.sv
// Shared types and default configuration for the BlackWidow fetch group unit.
package rfBlackWidowPkg;
    localparam int LANES_D     = 3;
    localparam int INSN_BITS_D = 40;
    localparam int IP_BITS_D   = 80;
    localparam int OFS_BITS_D  = 4;
    localparam int LINE_BITS_D = 672;
    localparam int BR_BIT_D    = 7;
    localparam logic [IP_BITS_D-1:0] RESET_IP_D = 80'h00FFFFFFFFFFFFFD0000;
    localparam int INSN_BYTES  = INSN_BITS_D / 8;

    typedef enum logic [1:0] {IDLE, RUN, MISS} fetch_state_t;

    typedef struct packed {
        logic [LANES_D-1:0][INSN_BITS_D-1:0] insn;
        logic [LANES_D-1:0]                  lane_v;
        logic [IP_BITS_D-1:0]                ip;
    } FetchGroup;
endpackage

// File: rtl/bw_fetch_lane_mask.sv
// Combinational lane extraction from an I-cache line: window at the byte offset,
// width clamp, stop-after-branch mask and the byte count the IP advances by.
module bw_fetch_lane_mask #(
    parameter int LANES     = 3,
    parameter int INSN_BITS = 40,
    parameter int OFS_BITS  = 4,
    parameter int LINE_BITS = 672,
    parameter int BR_BIT    = 7,
    parameter int ADV_W     = 16
) (
    input  logic [LINE_BITS-1:0]             i_line,
    input  logic [OFS_BITS-1:0]              i_ofs,
    input  logic [3:0]                       i_width,
    output logic [LANES-1:0][INSN_BITS-1:0]  o_insn,
    output logic [LANES-1:0]                 o_lane_v,
    output logic [ADV_W-1:0]                 o_adv
);
    localparam int GW = LANES * INSN_BITS;
    localparam logic [3:0] LANES4 = 4'(LANES);

    logic [GW-1:0] w_win;
    logic [3:0]    w_w;
    logic [3:0]    w_cnt;
    logic          w_stop;

    assign w_win  = GW'(i_line >> {i_ofs, 3'b000});
    assign o_insn = w_win;

    // width 0 still issues one instruction so fetch always makes progress
    assign w_w = (i_width == 4'd0)  ? 4'd1 :
                 (i_width > LANES4) ? LANES4 : i_width;

    always_comb begin
        w_stop   = 1'b0;
        w_cnt    = 4'd0;
        o_lane_v = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!w_stop && (4'(k) < w_w)) begin
                o_lane_v[k] = 1'b1;
                w_cnt       = w_cnt + 4'd1;
                w_stop      = o_insn[k][BR_BIT];
            end
        end
    end

    assign o_adv = ADV_W'(w_cnt) * ADV_W'(INSN_BITS / 8);
endmodule

// File: rtl/bw_fetch_group_unit.sv
// Multi-lane fetch stage: IP/FSM, miss counter and the valid/ready group register
// feeding decode.
module bw_fetch_group_unit import rfBlackWidowPkg::*; #(
    parameter int LANES     = LANES_D,
    parameter int INSN_BITS = INSN_BITS_D,
    parameter int IP_BITS   = IP_BITS_D,
    parameter int OFS_BITS  = OFS_BITS_D,
    parameter int LINE_BITS = LINE_BITS_D,
    parameter int BR_BIT    = BR_BIT_D,
    parameter logic [IP_BITS-1:0] RESET_IP = RESET_IP_D
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [IP_BITS-1:0]         ic_adr_o,
    output logic                       ic_req_o,
    input  logic                       ic_hit_i,
    input  logic [LINE_BITS-1:0]       ic_line_i,
    input  logic [3:0]                 width_i,
    input  logic                       redirect_i,
    input  logic [IP_BITS-1:0]         redirect_ip_i,
    output logic                       grp_valid_o,
    input  logic                       grp_ready_i,
    output logic [LANES*INSN_BITS-1:0] grp_insn_o,
    output logic [LANES-1:0]           grp_lane_v_o,
    output logic [IP_BITS-1:0]         grp_ip_o,
    output logic [31:0]                miss_cnt_o
);
    localparam int ADV_W = 16;

    fetch_state_t                  r_state;
    logic [IP_BITS-1:0]            r_ip;
    logic                          r_vld;
    logic [LANES-1:0][INSN_BITS-1:0] r_insn;
    logic [LANES-1:0]              r_lane_v;
    logic [IP_BITS-1:0]            r_gip;
    logic [31:0]                   r_miss;

    logic [LANES-1:0][INSN_BITS-1:0] w_insn;
    logic [LANES-1:0]              w_lane_v;
    logic [ADV_W-1:0]              w_adv;
    logic                          w_can;
    logic                          w_ld;

    bw_fetch_lane_mask #(
        .LANES(LANES), .INSN_BITS(INSN_BITS), .OFS_BITS(OFS_BITS),
        .LINE_BITS(LINE_BITS), .BR_BIT(BR_BIT), .ADV_W(ADV_W)
    ) u_mask (
        .i_line   (ic_line_i),
        .i_ofs    (r_ip[OFS_BITS-1:0]),
        .i_width  (width_i),
        .o_insn   (w_insn),
        .o_lane_v (w_lane_v),
        .o_adv    (w_adv)
    );

    assign w_can = ~r_vld | grp_ready_i;
    assign w_ld  = ic_hit_i & w_can & ~redirect_i & (r_state != IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_ip     <= RESET_IP;
            r_vld    <= 1'b0;
            r_insn   <= '0;
            r_lane_v <= '0;
            r_gip    <= '0;
            r_miss   <= '0;
        end else begin
            // redirect wins over any hit or transfer in the same cycle
            if (redirect_i && r_state != IDLE) begin
                r_ip     <= redirect_ip_i;
                r_vld    <= 1'b0;
                r_lane_v <= '0;
                r_state  <= RUN;
            end else begin
                if (w_ld) begin
                    r_insn   <= w_insn;
                    r_lane_v <= w_lane_v;
                    r_gip    <= r_ip;
                    r_vld    <= 1'b1;
                    r_ip     <= r_ip + IP_BITS'(w_adv);
                end else if (grp_ready_i) begin
                    r_vld    <= 1'b0;
                    r_lane_v <= '0;
                end
                case (r_state)
                    IDLE:    r_state <= RUN;
                    RUN:     if (!ic_hit_i && w_can) r_state <= MISS;
                    MISS:    if (ic_hit_i) r_state <= RUN;
                    default: r_state <= IDLE;
                endcase
            end
            if (r_state == MISS && r_miss != '1)
                r_miss <= r_miss + 32'd1;
        end
    end

    assign ic_adr_o     = r_ip;
    assign ic_req_o     = (r_state != IDLE);
    assign grp_valid_o  = r_vld;
    assign grp_insn_o   = r_insn;
    assign grp_lane_v_o = r_lane_v;
    assign grp_ip_o     = r_gip;
    assign miss_cnt_o   = r_miss;
endmodule

// File: tb/tb_bw_fetch_group_unit.sv
// Directed + randomized bench for bw_fetch_group_unit with a byte-level reference model.
module tb_bw_fetch_group_unit;
    import rfBlackWidowPkg::*;

    localparam int L      = 3;
    localparam int NB     = INSN_BYTES;
    localparam int LB     = 672;
    localparam int NBYTES = LB / 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [79:0]    ic_adr_o;
    logic           ic_req_o;
    logic           ic_hit_i;
    logic [LB-1:0]  ic_line_i;
    logic [3:0]     width_i;
    logic           redirect_i;
    logic [79:0]    redirect_ip_i;
    logic           grp_valid_o;
    logic           grp_ready_i;
    logic [119:0]   grp_insn_o;
    logic [2:0]     grp_lane_v_o;
    logic [79:0]    grp_ip_o;
    logic [31:0]    miss_cnt_o;

    bw_fetch_group_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_adr_o(ic_adr_o), .ic_req_o(ic_req_o),
        .ic_hit_i(ic_hit_i), .ic_line_i(ic_line_i),
        .width_i(width_i), .redirect_i(redirect_i), .redirect_ip_i(redirect_ip_i),
        .grp_valid_o(grp_valid_o), .grp_ready_i(grp_ready_i),
        .grp_insn_o(grp_insn_o), .grp_lane_v_o(grp_lane_v_o),
        .grp_ip_o(grp_ip_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    // reference model: line as bytes, state as "idle/run/miss" names
    logic [7:0]   lb [NBYTES];
    logic [79:0]  m_ip, m_gip;
    int           m_st;              // 0 idle, 1 run, 2 miss
    logic         m_vld;
    logic [2:0]   m_lv;
    logic [119:0] m_insn;
    logic [31:0]  m_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ip = RESET_IP_D; m_gip = '0; m_st = 0; m_vld = 1'b0;
        m_lv = '0; m_insn = '0; m_cnt = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/adr"},  128'(ic_adr_o),     128'(m_ip));
        chk({tag, "/req"},  128'(ic_req_o),     128'(m_st != 0));
        chk({tag, "/vld"},  128'(grp_valid_o),  128'(m_vld));
        chk({tag, "/lv"},   128'(grp_lane_v_o), 128'(m_lv));
        chk({tag, "/insn"}, 128'(grp_insn_o),   128'(m_insn));
        chk({tag, "/gip"},  128'(grp_ip_o),     128'(m_gip));
        chk({tag, "/miss"}, 128'(miss_cnt_o),   128'(m_cnt));
    endtask

    // random line with branch flags only on the chosen lanes at the current offset
    task automatic set_line(input logic [2:0] br);
        int o;
        o = int'(m_ip[3:0]);
        for (int i = 0; i < NBYTES; i++) lb[i] = 8'($urandom()) & 8'h7f;
        for (int k = 0; k < L; k++) if (br[k]) lb[o + k*NB][7] = 1'b1;
        for (int i = 0; i < NBYTES; i++) ic_line_i[i*8 +: 8] = lb[i];
    endtask

    task automatic model_step();
        int o, w, n, old_st;
        logic [119:0] g;
        logic [2:0] lv;
        bit can, ld, stop;
        o = int'(m_ip[3:0]);
        w = (width_i == 0) ? 1 : ((int'(width_i) > L) ? L : int'(width_i));
        g = '0; lv = '0; n = 0; stop = 0;
        for (int k = 0; k < L; k++) begin
            for (int b = 0; b < NB; b++) g[(k*NB + b)*8 +: 8] = lb[o + k*NB + b];
            if (!stop && k < w) begin
                lv[k] = 1'b1; n++;
                stop = lb[o + k*NB][7];
            end
        end
        can = !m_vld || grp_ready_i;
        ld  = ic_hit_i && can && !redirect_i && m_st != 0;
        old_st = m_st;
        if (redirect_i && m_st != 0) begin
            m_ip = redirect_ip_i; m_vld = 1'b0; m_lv = '0; m_st = 1;
        end else begin
            if (ld) begin
                m_insn = g; m_lv = lv; m_gip = m_ip; m_vld = 1'b1;
                m_ip = m_ip + 80'(n * NB);
            end else if (grp_ready_i) begin
                m_vld = 1'b0; m_lv = '0;
            end
            if (m_st == 0) m_st = 1;
            else if (m_st == 1 && !ic_hit_i && can) m_st = 2;
            else if (m_st == 2 && ic_hit_i) m_st = 1;
        end
        if (old_st == 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [79:0] prev_adr, prev_gip;
        logic [119:0] prev_insn;
        for (int i = 0; i < NBYTES; i++) lb[i] = '0;
        rst_i = 1'b0; ic_hit_i = 1'b0; ic_line_i = '0; width_i = 4'd3;
        redirect_i = 1'b0; redirect_ip_i = '0; grp_ready_i = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        rst_i = 1'b1;

        // IDLE cycle, then first fetch address
        ic_hit_i = 1'b1; set_line(3'b000);
        cycle("idle");
        chk("first_adr", 128'(ic_adr_o), 128'(80'h00FFFFFFFFFFFFFD0000));

        // straight-line code, full width
        for (int i = 0; i < 3; i++) begin
            prev_adr = ic_adr_o;
            set_line(3'b000); cycle("nobr");
            chk("nobr_lv", 128'(grp_lane_v_o), 128'(3'b111));
            chk("nobr_adv", 128'(ic_adr_o - prev_adr), 128'(15));
        end

        // byte offset 0xA
        redirect_i = 1'b1; redirect_ip_i = 80'h10A; set_line(3'b000);
        cycle("redir_a");
        redirect_i = 1'b0; set_line(3'b000);
        cycle("ofsA");
        chk("ofsA_lane0", 128'(grp_insn_o[39:0]), 128'({lb[14], lb[13], lb[12], lb[11], lb[10]}));

        // branch truncation
        prev_adr = ic_adr_o;
        set_line(3'b010); cycle("br1");
        chk("br1_lv", 128'(grp_lane_v_o), 128'(3'b011));
        chk("br1_adv", 128'(ic_adr_o - prev_adr), 128'(10));
        prev_adr = ic_adr_o;
        set_line(3'b001); cycle("br0");
        chk("br0_lv", 128'(grp_lane_v_o), 128'(3'b001));
        chk("br0_adv", 128'(ic_adr_o - prev_adr), 128'(5));

        // backpressure
        grp_ready_i = 1'b0;
        prev_adr = ic_adr_o; prev_gip = grp_ip_o; prev_insn = grp_insn_o;
        for (int i = 0; i < 4; i++) begin
            set_line(3'b000); cycle("stall");
            chk("stall_adr", 128'(ic_adr_o), 128'(prev_adr));
            chk("stall_gip", 128'(grp_ip_o), 128'(prev_gip));
            chk("stall_insn", 128'(grp_insn_o), 128'(prev_insn));
        end
        grp_ready_i = 1'b1;
        set_line(3'b000); cycle("release");
        chk("release_gip", 128'(grp_ip_o), 128'(prev_adr));
        set_line(3'b000); cycle("follow");

        // miss run
        ic_hit_i = 1'b0;
        prev_adr = ic_adr_o;
        for (int i = 0; i < 6; i++) begin
            cycle("miss");
            chk("miss_adr", 128'(ic_adr_o), 128'(prev_adr));
        end
        chk("miss_drain", 128'(grp_valid_o), 128'(0));
        ic_hit_i = 1'b1; set_line(3'b000);
        cycle("miss_end");
        chk("miss_cnt6", 128'(miss_cnt_o), 128'(6));

        // redirect beats hit + ready
        redirect_i = 1'b1; redirect_ip_i = 80'h1234; set_line(3'b000);
        cycle("redir");
        chk("redir_vld", 128'(grp_valid_o), 128'(0));
        chk("redir_adr", 128'(ic_adr_o), 128'(80'h1234));
        redirect_i = 1'b0; width_i = 4'd0; set_line(3'b000);
        cycle("w0");
        chk("w0_lv", 128'(grp_lane_v_o), 128'(3'b001));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ic_hit_i      = ($urandom_range(3) != 0);
            grp_ready_i   = ($urandom_range(3) != 0);
            redirect_i    = ($urandom_range(31) == 0);
            redirect_ip_i = {16'($urandom()), 32'($urandom()), 32'($urandom())};
            width_i       = 4'($urandom_range(4));
            set_line(3'($urandom()) & 3'($urandom()));
            cycle("rand");
        end

        // asynchronous reset in mid-run
        redirect_i = 1'b0; ic_hit_i = 1'b1; grp_ready_i = 1'b1; width_i = 4'd3;
        set_line(3'b000); cycle("pre_rst");
        rst_i = 1'b0;
        model_reset();
        #2;
        check_all("async_rst");
        @(posedge clk_i); #1;
        check_all("rst_hold");
        #3 rst_i = 1'b1;
        set_line(3'b000);
        cycle("idle2");
        chk("first_adr2", 128'(ic_adr_o), 128'(80'h00FFFFFFFFFFFFFD0000));
        set_line(3'b000);
        cycle("run2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
